// File: rtl/frame_ctrl.sv
// frame_ctrl: frame sequencer gating line-buffer windows into the core with result credit tracking.
// Optional FRAME_SEG_COUNT_EN enables the completed-frame BCD display counter.
`default_nettype none

module frame_ctrl #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int MAX_OUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       preprocess_done_i,
  input  logic       buf_valid_i,
  output logic       buf_rd_o,
  input  logic       core_ready_i,
  output logic       win_valid_o,
  input  logic       core_valid_i,
  output logic [2:0] state_o,
  output logic [9:0] cnt_col_o,
  output logic [9:0] cnt_row_o,
  output logic       busy_o,
  output logic       frame_done_o,
  output logic       err_o,
  output logic       n_segment_up_o,
  output logic [3:0] seg_cnt_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PRELOAD = 3'd1;
  localparam logic [2:0] S_STREAM  = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
  localparam logic [9:0] ROW_LAST = 10'(IMG_H - 1);
  localparam logic [3:0] CREDIT   = 4'(MAX_OUT);

  logic [2:0] state;
  logic [2:0] next_state;
  logic [3:0] out_cnt;
  logic       frame_start;
  logic       last_xfer;

  assign frame_start = (state == S_IDLE) && start_i;
  assign last_xfer   = buf_rd_o && (cnt_col_o == COL_LAST) && (cnt_row_o == ROW_LAST);
  assign state_o     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start_i)           next_state = S_PRELOAD;
      S_PRELOAD: if (preprocess_done_i) next_state = S_STREAM;
      S_STREAM:  if (last_xfer)         next_state = S_DRAIN;
      S_DRAIN:   if (out_cnt == 4'd0)   next_state = S_DONE;
      S_DONE:                           next_state = S_IDLE;
      default:                          next_state = S_IDLE;
    endcase
  end

  // Window gating depends only on registered state/credit and live buffer/core handshakes.
  always_comb begin
    win_valid_o = 1'b0;
    buf_rd_o    = 1'b0;
    if ((state == S_STREAM) && buf_valid_i && (out_cnt < CREDIT)) begin
      win_valid_o = 1'b1;
      buf_rd_o    = core_ready_i;
    end
  end

  // Row reaches IMG_H after the final wrap and holds there since no further transfers occur.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_col_o <= 10'd0;
      cnt_row_o <= 10'd0;
    end else if (frame_start) begin
      cnt_col_o <= 10'd0;
      cnt_row_o <= 10'd0;
    end else if (buf_rd_o) begin
      if (cnt_col_o == COL_LAST) begin
        cnt_col_o <= 10'd0;
        cnt_row_o <= cnt_row_o + 10'd1;
      end else begin
        cnt_col_o <= cnt_col_o + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= 4'd0;
      err_o   <= 1'b0;
    end else if (frame_start) begin
      out_cnt <= 4'd0;
      err_o   <= 1'b0;
    end else begin
      case ({buf_rd_o, core_valid_i})
        2'b10: out_cnt <= out_cnt + 4'd1;
        2'b01: begin
          if (out_cnt == 4'd0) err_o   <= 1'b1;
          else                 out_cnt <= out_cnt - 4'd1;
        end
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      busy_o       <= (next_state != S_IDLE);
      frame_done_o <= (next_state == S_DONE);
    end
  end

`ifdef FRAME_SEG_COUNT_EN
  logic enter_done;
  assign enter_done = (next_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_segment_up_o <= 1'b1;
      seg_cnt_o      <= 4'd0;
    end else begin
      n_segment_up_o <= !enter_done;
      if (enter_done) seg_cnt_o <= (seg_cnt_o == 4'd9) ? 4'd0 : seg_cnt_o + 4'd1;
    end
  end
`else
  assign n_segment_up_o = 1'b1;
  assign seg_cnt_o      = 4'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_ctrl.sv
// Directed self-checking bench for frame_ctrl with IMG_W=4, IMG_H=2, MAX_OUT=2.
`default_nettype none

module tb_frame_ctrl;

`ifdef FRAME_SEG_COUNT_EN
  localparam int SEG_EN = 1;
`else
  localparam int SEG_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       preprocess_done_i = 1'b0;
  logic       buf_valid_i = 1'b0;
  logic       buf_rd_o;
  logic       core_ready_i = 1'b0;
  logic       win_valid_o;
  logic       core_valid_i = 1'b0;
  logic [2:0] state_o;
  logic [9:0] cnt_col_o;
  logic [9:0] cnt_row_o;
  logic       busy_o;
  logic       frame_done_o;
  logic       err_o;
  logic       n_segment_up_o;
  logic [3:0] seg_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int seg_pulses = 0;

  frame_ctrl #(.IMG_W(4), .IMG_H(2), .MAX_OUT(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_i           (start_i),
    .preprocess_done_i (preprocess_done_i),
    .buf_valid_i       (buf_valid_i),
    .buf_rd_o          (buf_rd_o),
    .core_ready_i      (core_ready_i),
    .win_valid_o       (win_valid_o),
    .core_valid_i      (core_valid_i),
    .state_o           (state_o),
    .cnt_col_o         (cnt_col_o),
    .cnt_row_o         (cnt_row_o),
    .busy_o            (busy_o),
    .frame_done_o      (frame_done_o),
    .err_o             (err_o),
    .n_segment_up_o    (n_segment_up_o),
    .seg_cnt_o         (seg_cnt_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done_o)    done_cnt++;
    if (!n_segment_up_o) seg_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got running, want finished)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    preprocess_done_i = 1'b1;
    tick();
    preprocess_done_i = 1'b0;
  endtask

  // Core model: returns each result the cycle after its window was accepted.
  task automatic run_frame();
    int   guard;
    logic prev;
    begin_frame();
    buf_valid_i = 1'b1;
    core_ready_i = 1'b1;
    core_valid_i = 1'b0;
    guard = 0;
    while (state_o != 3'd0 && guard < 60) begin
      #1 prev = buf_rd_o;
      tick();
      core_valid_i = prev;
      guard++;
    end
    buf_valid_i = 1'b0;
    core_ready_i = 1'b0;
    core_valid_i = 1'b0;
    check("frame_complete_in_budget", 32'(guard < 60), 32'd1);
  endtask

  initial begin
    int d0;
    int s0;

    // Reset state
    #12;
    check("rst_state", 32'(state_o), 0);
    check("rst_col", 32'(cnt_col_o), 0);
    check("rst_row", 32'(cnt_row_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(frame_done_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_buf_rd", 32'(buf_rd_o), 0);
    check("rst_win_valid", 32'(win_valid_o), 0);
    check("rst_nseg", 32'(n_segment_up_o), 1);
    check("rst_seg_cnt", 32'(seg_cnt_o), 0);
    rst_n = 1'b1;
    tick();

    // Nominal frame with start_i ignored mid-stream
    d0 = done_cnt;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("nom_preload_state", 32'(state_o), 1);
    check("nom_busy", 32'(busy_o), 1);
    preprocess_done_i = 1'b1;
    tick();
    preprocess_done_i = 1'b0;
    check("nom_stream_state", 32'(state_o), 2);
    buf_valid_i = 1'b1;
    core_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      start_i = (i == 3);
      #1;
      check("nom_col", 32'(cnt_col_o), 32'(i % 4));
      check("nom_row", 32'(cnt_row_o), 32'(i / 4));
      check("nom_buf_rd", 32'(buf_rd_o), 1);
      tick();
      start_i = 1'b0;
      core_valid_i = 1'b1;
      if (i == 3) check("start_in_stream_ignored", 32'(state_o), 2);
    end
    check("nom_drain_state", 32'(state_o), 3);
    check("nom_end_col", 32'(cnt_col_o), 0);
    check("nom_end_row", 32'(cnt_row_o), 2);
    buf_valid_i = 1'b0;
    core_ready_i = 1'b0;
    tick();
    core_valid_i = 1'b0;
    check("drain_after_last_result", 32'(state_o), 3);
    tick();
    check("done_state", 32'(state_o), 4);
    check("done_pulse", 32'(frame_done_o), 1);
    tick();
    check("idle_after_done", 32'(state_o), 0);
    check("idle_busy", 32'(busy_o), 0);
    check("done_deassert", 32'(frame_done_o), 0);
    check("nom_err", 32'(err_o), 0);
    check("nom_done_count", 32'(done_cnt - d0), 1);

    // Credit stall and simultaneous transfer/result
    begin_frame();
    buf_valid_i = 1'b1;
    core_ready_i = 1'b1;
    core_valid_i = 1'b0;
    tick();
    tick();
    #1;
    check("stall_col", 32'(cnt_col_o), 2);
    check("stall_win_valid", 32'(win_valid_o), 0);
    check("stall_buf_rd", 32'(buf_rd_o), 0);
    tick();
    check("stall_hold_col", 32'(cnt_col_o), 2);
    core_valid_i = 1'b1;
    #1;
    check("no_comb_from_core_valid", 32'(win_valid_o), 0);
    tick();
    core_valid_i = 1'b0;
    #1;
    check("credit_release_win", 32'(win_valid_o), 1);
    tick();
    #1;
    check("credit_xfer_col", 32'(cnt_col_o), 3);
    check("credit_full_again", 32'(win_valid_o), 0);
    core_valid_i = 1'b1;
    tick();
    tick();
    core_valid_i = 1'b0;
    #1;
    check("same_cycle_col", 32'(cnt_col_o), 0);
    check("same_cycle_row", 32'(cnt_row_o), 1);
    check("same_cycle_count_kept", 32'(win_valid_o), 1);
    tick();
    core_valid_i = 1'b1;
    tick();
    core_valid_i = 1'b0;
    tick();
    #1;
    check("pre_reset_col", 32'(cnt_col_o), 2);
    check("pre_reset_row", 32'(cnt_row_o), 1);

    // Asynchronous reset mid-frame, then restart
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(state_o), 0);
    check("async_rst_col", 32'(cnt_col_o), 0);
    check("async_rst_row", 32'(cnt_row_o), 0);
    check("async_rst_busy", 32'(busy_o), 0);
    check("async_rst_win", 32'(win_valid_o), 0);
    rst_n = 1'b1;
    begin_frame();
    #1;
    check("restart_state", 32'(state_o), 2);
    check("restart_col", 32'(cnt_col_o), 0);
    check("restart_row", 32'(cnt_row_o), 0);
    check("restart_win", 32'(win_valid_o), 1);
    rst_n = 1'b0;
    buf_valid_i = 1'b0;
    core_ready_i = 1'b0;
    #1 rst_n = 1'b1;

    // Result with nothing outstanding sets a sticky error
    tick();
    core_valid_i = 1'b1;
    tick();
    core_valid_i = 1'b0;
    check("err_set", 32'(err_o), 1);
    tick();
    tick();
    check("err_sticky", 32'(err_o), 1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("err_cleared_by_start", 32'(err_o), 0);
    check("err_start_state", 32'(state_o), 1);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    tick();

    // Ten back-to-back frames for the display counter
    d0 = done_cnt;
    s0 = seg_pulses;
    for (int f = 0; f < 10; f++) begin
      run_frame();
      if (f == 2) check("seg_cnt_after_3", 32'(seg_cnt_o), 32'(SEG_EN * 3));
    end
    check("ten_frames_done", 32'(done_cnt - d0), 10);
    check("seg_pulses", 32'(seg_pulses - s0), 32'(SEG_EN * 10));
    check("seg_cnt_wrap", 32'(seg_cnt_o), 0);
    check("nseg_idle_high", 32'(n_segment_up_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
